// File: rtl/lif_neuron.sv
// lif_neuron -- leaky integrate-and-fire neuron fed by the mac block.
//
// Each accepted weighted sum is one time step. On that step the membrane
// potential leaks by vmem >> LEAK_SHIFT, the sum is added with saturation,
// and the neuron fires (one-cycle spike, potential cleared) when the result
// reaches thresh.
//
// Optional feature macro: LIF_REFRACTORY_EN
//   defined   -> after a spike the neuron spends REFRAC_CYCLES cycles in a
//                refractory state with in_ready low (back-pressures mac).
//   undefined -> no refractory state; refrac is tied low and REFRAC_CYCLES
//                is ignored.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   sum_valid    sum is valid this cycle
//   sum          weighted spike sum from mac (unsigned, zero-extended)
//   thresh       firing threshold, compared on every transfer (not latched)
//   in_ready     neuron accepts sum this cycle (combinational)
//   spike        one-cycle output spike
//   vmem         registered membrane potential
//   refrac       neuron is refractory
//   spike_count  spikes since reset, wraps at 2^16
module lif_neuron #(
   parameter int SUM_W         = 21,
   parameter int VMEM_W        = 24,
   parameter int LEAK_SHIFT    = 3,
   parameter int REFRAC_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sum_valid,
   input  logic [SUM_W-1:0]  sum,
   input  logic [VMEM_W-1:0] thresh,
   output logic              in_ready,
   output logic              spike,
   output logic [VMEM_W-1:0] vmem,
   output logic              refrac,
   output logic [15:0]       spike_count
);

   logic [VMEM_W-1:0] vmem_r;
   logic [VMEM_W-1:0] leak_s;
   logic [VMEM_W:0]   v_wide_s;
   logic [VMEM_W-1:0] v_next_s;
   logic              spike_r;
   logic [15:0]       count_r;
   logic              integ_s;
   logic              transfer_s;
   logic              fire_s;

   // Leak, add and saturate; one extra bit catches the overflow.
   always_comb begin
      leak_s   = vmem_r >> LEAK_SHIFT;
      v_wide_s = {1'b0, vmem_r} - {1'b0, leak_s}
               + {{(VMEM_W + 1 - SUM_W){1'b0}}, sum};
      if (v_wide_s[VMEM_W]) begin
         v_next_s = {VMEM_W{1'b1}};
      end else begin
         v_next_s = v_wide_s[VMEM_W-1:0];
      end
   end

   assign in_ready   = integ_s && !rst;
   assign transfer_s = sum_valid && in_ready;
   assign fire_s     = transfer_s && (v_next_s >= thresh);

   // Membrane potential, spike pulse and spike counter.
   // The refractory state is only entered on a firing edge, which clears
   // vmem, and no transfer happens there, so vmem stays 0 throughout it.
   always_ff @(posedge clk) begin
      if (rst) begin
         vmem_r  <= {VMEM_W{1'b0}};
         spike_r <= 1'b0;
         count_r <= 16'd0;
      end else begin
         spike_r <= fire_s;
         if (fire_s) begin
            vmem_r  <= {VMEM_W{1'b0}};
            count_r <= count_r + 16'd1;
         end else if (transfer_s) begin
            vmem_r  <= v_next_s;
         end else begin
            vmem_r  <= vmem_r;
         end
      end
   end

`ifdef LIF_REFRACTORY_EN
   localparam int CNT_W = $clog2(REFRAC_CYCLES + 1);

   typedef enum logic [0:0] {
      ST_INTEG  = 1'b0,
      ST_REFRAC = 1'b1
   } state_t;

   state_t           state_r;
   state_t           state_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_s;
   logic             refrac_r;

   // State register, refractory counter and registered refrac flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= ST_INTEG;
         cnt_r    <= {CNT_W{1'b0}};
         refrac_r <= 1'b0;
      end else begin
         state_r  <= state_s;
         cnt_r    <= cnt_s;
         refrac_r <= (state_s == ST_REFRAC);
      end
   end

   // Next state: a count of 1 means this is the last refractory cycle.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      case (state_r)
         ST_INTEG: begin
            if (fire_s) begin
               state_s = ST_REFRAC;
               cnt_s   = CNT_W'(REFRAC_CYCLES);
            end else begin
               state_s = ST_INTEG;
            end
         end
         ST_REFRAC: begin
            cnt_s = cnt_r - CNT_W'(1);
            if (cnt_r == CNT_W'(1)) begin
               state_s = ST_INTEG;
            end else begin
               state_s = ST_REFRAC;
            end
         end
         default: begin
            state_s = ST_INTEG;
            cnt_s   = {CNT_W{1'b0}};
         end
      endcase
   end

   // Output decode: inputs are accepted only while integrating.
   always_comb begin
      integ_s = 1'b0;
      case (state_r)
         ST_INTEG:  integ_s = 1'b1;
         ST_REFRAC: integ_s = 1'b0;
         default:   integ_s = 1'b0;
      endcase
   end

   assign refrac = refrac_r;
`else
   assign integ_s = 1'b1;
   assign refrac  = 1'b0;
`endif

   assign vmem        = vmem_r;
   assign spike       = spike_r;
   assign spike_count = count_r;

endmodule

// File: tb/tb_lif_neuron.sv
// Self-checking bench for lif_neuron. A behavioural model predicts every
// cycle's outputs; predictions are queued when stimulus is driven and popped
// and compared after the clock edge. Directed constant checks cover the
// worked examples (leak decay, firing, threshold boundary, stall, reset).
module tb_lif_neuron;

   localparam int  LEAK = 3;
   localparam int  RC   = 4;
   localparam longint VMAX = 64'd16777215;
`ifdef LIF_REFRACTORY_EN
   localparam bit REF_EN = 1'b1;
`else
   localparam bit REF_EN = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        sum_valid;
   logic [20:0] sum;
   logic [23:0] thresh;
   logic        in_ready;
   logic        spike;
   logic [23:0] vmem;
   logic        refrac;
   logic [15:0] spike_count;

   typedef struct {
      logic [23:0] vmem;
      logic        spike;
      logic        refrac;
      logic [15:0] count;
   } exp_t;

   exp_t sb[$];

   int checks   = 0;
   int failures = 0;

   // model state
   longint m_vmem   = 0;
   int     m_count  = 0;
   bit     m_integ  = 1'b1;
   int     m_cnt    = 0;
   bit     m_refrac = 1'b0;
   bit     m_spike  = 1'b0;

   lif_neuron #(
      .SUM_W(21), .VMEM_W(24), .LEAK_SHIFT(LEAK), .REFRAC_CYCLES(RC)
   ) dut (
      .clk(clk), .rst(rst), .sum_valid(sum_valid), .sum(sum),
      .thresh(thresh), .in_ready(in_ready), .spike(spike), .vmem(vmem),
      .refrac(refrac), .spike_count(spike_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Drive one cycle, predict its result, clock it and compare.
   task automatic cycle(input bit r, input bit v, input int s, input int th);
      exp_t   e;
      longint vn;
      bit     rdy;
      rst       = r;
      sum_valid = v;
      sum       = s[20:0];
      thresh    = th[23:0];
      #1;
      rdy = m_integ && !r;
      check("in_ready", {31'd0, in_ready}, {31'd0, rdy});
      m_spike = 1'b0;
      if (r) begin
         m_vmem = 0; m_count = 0; m_integ = 1'b1; m_cnt = 0; m_refrac = 1'b0;
      end else if (rdy && v) begin
         vn = m_vmem - (m_vmem >> LEAK) + longint'(s);
         if (vn > VMAX) vn = VMAX;
         if (vn >= longint'(th)) begin
            m_vmem  = 0;
            m_spike = 1'b1;
            m_count = (m_count + 1) % 65536;
            if (REF_EN) begin
               m_integ = 1'b0; m_cnt = RC; m_refrac = 1'b1;
            end
         end else begin
            m_vmem = vn;
         end
      end else if (!m_integ) begin
         if (m_cnt == 1) begin
            m_integ = 1'b1; m_refrac = 1'b0;
         end
         m_cnt--;
      end
      e.vmem = m_vmem[23:0]; e.spike = m_spike;
      e.refrac = m_refrac;   e.count = m_count[15:0];
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check("sb_empty", 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check("vmem",        {8'd0, vmem},         {8'd0, e.vmem});
         check("spike",       {31'd0, spike},       {31'd0, e.spike});
         check("refrac",      {31'd0, refrac},      {31'd0, e.refrac});
         check("spike_count", {16'd0, spike_count}, {16'd0, e.count});
      end
   endtask

   task automatic idle(input int n, input int th);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0, th);
   endtask

   initial begin
      int stalls;
      rst = 1'b1; sum_valid = 1'b0; sum = 21'd0; thresh = 24'd64;

      // reset held 3 cycles with a valid sum presented
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 100, 64);
      check("rst_vmem", {8'd0, vmem}, 32'd0);
      check("rst_count", {16'd0, spike_count}, 32'd0);
      idle(1, 64);

      // leak decay 40, 35, 31
      cycle(1'b0, 1'b1, 40, 64); check("leak_40", {8'd0, vmem}, 32'd40);
      cycle(1'b0, 1'b1, 0, 64);  check("leak_35", {8'd0, vmem}, 32'd35);
      cycle(1'b0, 1'b1, 0, 64);  check("leak_31", {8'd0, vmem}, 32'd31);
      idle(2, 64);               check("leak_hold", {8'd0, vmem}, 32'd31);

      // fire: 40 then 40 -> 75 >= 64
      cycle(1'b1, 1'b0, 0, 64);
      cycle(1'b0, 1'b1, 40, 64);
      cycle(1'b0, 1'b1, 40, 64);
      check("fire_spike", {31'd0, spike}, 32'd1);
      check("fire_vmem", {8'd0, vmem}, 32'd0);
      check("fire_count", {16'd0, spike_count}, 32'd1);
      check("fire_refrac", {31'd0, refrac}, {31'd0, REF_EN});
      idle(6, 64);

      // threshold boundary: equality fires, one above does not
      cycle(1'b1, 1'b0, 0, 75);
      cycle(1'b0, 1'b1, 40, 75);
      cycle(1'b0, 1'b1, 40, 75);
      check("th75_spike", {31'd0, spike}, 32'd1);
      idle(6, 75);
      cycle(1'b1, 1'b0, 0, 76);
      cycle(1'b0, 1'b1, 40, 76);
      cycle(1'b0, 1'b1, 40, 76);
      check("th76_spike", {31'd0, spike}, 32'd0);
      check("th76_vmem", {8'd0, vmem}, 32'd75);

      // stall: sum held valid through the refractory period
      cycle(1'b1, 1'b0, 0, 64);
      cycle(1'b0, 1'b1, 40, 64);
      cycle(1'b0, 1'b1, 40, 64);
      stalls = 0;
      for (int i = 0; i < 10; i++) begin
         if (m_integ) break;
         cycle(1'b0, 1'b1, 10, 64);
         stalls++;
      end
      check("stall_len", stalls, REF_EN ? RC : 0);
      cycle(1'b0, 1'b1, 10, 64);
      check("stall_vmem", {8'd0, vmem}, 32'd10);

      // reset in the second refractory cycle
      cycle(1'b1, 1'b0, 0, 64);
      cycle(1'b0, 1'b1, 40, 64);
      cycle(1'b0, 1'b1, 40, 64);
      cycle(1'b0, 1'b0, 0, 64);
      cycle(1'b1, 1'b0, 0, 64);
      check("midrst_refrac", {31'd0, refrac}, 32'd0);
      check("midrst_count", {16'd0, spike_count}, 32'd0);
      cycle(1'b0, 1'b0, 0, 64);
      check("midrst_ready", {31'd0, in_ready}, 32'd1);

      // random traffic, including thresh=0 and large sums
      for (int i = 0; i < 60; i++) begin
         int th;
         int s;
         case ($urandom_range(0, 3))
            0:       th = 0;
            1:       th = int'($urandom_range(0, 200));
            2:       th = 16777215;
            default: th = int'($urandom_range(0, 16777215));
         endcase
         s = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 2097151))
                                         : int'($urandom_range(0, 50));
         cycle(($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0), s, th);
      end

      check("sb_drained", sb.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lif_neuron.md
# lif_neuron

Leaky integrate-and-fire neuron stage sitting directly downstream of the `mac` block. Each accepted 21-bit weighted spike sum from `mac` is one time step: the neuron leaks its membrane potential, adds the sum, and emits a one-cycle output spike when the potential reaches the threshold. After a spike, the neuron resets its potential and, optionally, enters a refractory period that back-pressures the MAC.

## Interface
- `SUM_W`, 21, width of the incoming `sum` from `mac` (unsigned)
- `VMEM_W`, 24, membrane potential width (unsigned)
- `LEAK_SHIFT`, 3, leak = vmem >> LEAK_SHIFT per time step; legal range 1..VMEM_W-1
- `REFRAC_CYCLES`, 4, refractory length in clock cycles; must be >= 1
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `sum_valid`  in  1  `sum` is valid this cycle
- `sum`  in  SUM_W  weighted spike sum from `mac`
- `thresh`  in  VMEM_W  firing threshold, sampled every cycle
- `in_ready`  out  1  neuron accepts `sum` this cycle
- `spike`  out  1  output spike, one-cycle pulse
- `vmem`  out  VMEM_W  registered membrane potential
- `refrac`  out  1  neuron is in the refractory state
- `spike_count`  out  16  total spikes since reset, wraps at 2^16

## Operation
- States: INTEG, REFRAC (REFRAC exists only with `LIF_REFRACTORY_EN`). Reset state is INTEG.
- Reset values: `vmem`=0, `spike`=0, `refrac`=0, `spike_count`=0, refractory counter=0. `in_ready`=0 while `rst` is high.
- `in_ready` = (state==INTEG) && !rst. This is a combinational output.
- Transfer: `sum_valid && in_ready` at a rising edge. When `sum_valid` is high and `in_ready` is low, upstream holds `sum` stable. No data is ever dropped.
- INTEG, on transfer:
  - v_next = sat(vmem - (vmem >> LEAK_SHIFT) + sum), computed at VMEM_W+1 bits.
  - Saturates at 2^VMEM_W-1.
  - `sum` is zero-extended.
- INTEG, on transfer with v_next >= `thresh` (this includes equality, and `thresh`=0 fires on every transfer):
  - `vmem` <= 0.
  - `spike` <= 1.
  - `spike_count` <= `spike_count`+1.
  - With `LIF_REFRACTORY_EN`: state <= REFRAC, counter <= REFRAC_CYCLES, `refrac` <= 1.
- INTEG, on transfer below threshold: `vmem` <= v_next.
- INTEG, no transfer: `vmem` holds. Leak is applied only on accepted time steps.
- `spike` is 0 in every cycle not covered by the firing rule above.
- REFRAC:
  - Counter decrements each cycle. `vmem` is held at 0 and inputs are not accepted.
  - When the counter equals 1, the next edge returns the state to INTEG and sets `refrac` <= 0.
- `rst` has priority over all events, including a threshold crossing at the same edge and any point in REFRAC.

## Timing
- Latency: a transfer at edge N produces updated `vmem` and `spike` visible after edge N (1 cycle).
- `spike` stays high for exactly one cycle.
- REFRAC is entered at the firing edge N. `refrac`=1 and `in_ready`=0 for exactly REFRAC_CYCLES cycles after N. `in_ready` returns to 1 after edge N+REFRAC_CYCLES.
- Without the macro: `in_ready` stays 1 during the spike cycle, so back-to-back transfers are allowed every cycle.
- `thresh` changes take effect on the next transfer compare; there is no latching.

## Configuration
- `LIF_REFRACTORY_EN` defined:
  - REFRAC state, refractory counter and `refrac` output are implemented as described above.
- `LIF_REFRACTORY_EN` undefined:
  - No REFRAC state and no counter.
  - `refrac` is tied to 0.
  - After a spike the neuron stays in INTEG.
  - `REFRAC_CYCLES` is ignored.

## Test plan
Defaults apply, `thresh`=64, macro defined, unless stated otherwise.
- Reset: hold `rst` for 3 cycles with `sum_valid`=1 and `sum`=100 -> `in_ready`=0 during reset; `vmem`=0, `spike`=0, `refrac`=0 and `spike_count`=0; after release `in_ready`=1.
- Leak decay: transfer `sum`=40, then `sum`=0, then `sum`=0 -> `vmem` = 40, 35, 31. `spike` never asserts.
- Fire: transfer 40 then 40 -> v_next=75 >= 64. `spike`=1 for one cycle, `vmem`=0, `spike_count`=1, `refrac`=1 and `in_ready`=0 for 4 cycles, then `in_ready`=1.
- Threshold boundary: the same 40, 40 sequence with `thresh`=75 -> fires. With `thresh`=76 -> no spike and `vmem`=75.
- Stall: hold `sum_valid`=1, `sum`=10 through REFRAC -> no transfer while `in_ready`=0; first transfer on the first INTEG cycle, giving `vmem`=10.
- Reset mid-refractory: assert `rst` in the 2nd REFRAC cycle -> next cycle `refrac`=0 and `spike_count`=0; after release `in_ready`=1. Repeat the fire test without the macro -> `refrac` stays 0 and `in_ready` stays 1 in the spike cycle.
